// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Imported by both the next-address mux and the sequencer top.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_RUN  = 2'd0,
        PC_ISR  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational priority select of the address the PC loads next.
// Also reports which event won this cycle so the sequencer can update state and epc.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] IRQ_VECTOR   = ADDR_W'(32'h0000_0080)
) (
    input  logic              reset,
    input  pc_state_t         state,
    input  logic [ADDR_W-1:0] current_address,
    input  logic [ADDR_W-1:0] epc,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              eret,
    input  logic              halt,
    input  logic              irq_req,
    output logic [ADDR_W-1:0] new_address,
    output logic [ADDR_W-1:0] redirect,
    output logic              take_irq,
    output logic              take_eret,
    output logic              take_halt
);

    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] branch_aligned;
    logic [ADDR_W-1:0] jump_aligned;

    // Wraps silently at the top of the address space.
    assign seq            = current_address + ADDR_W'(INSTR_BYTES);
    assign branch_aligned = {branch_target[ADDR_W-1:2], 2'b00};
    assign jump_aligned   = {jump_target[ADDR_W-1:2], 2'b00};
    assign redirect       = jump ? jump_aligned : (branch_taken ? branch_aligned : seq);

    always_comb begin
        new_address = redirect;
        take_irq    = 1'b0;
        take_eret   = 1'b0;
        take_halt   = 1'b0;
        if (reset) begin
            new_address = RESET_VECTOR;
        end else if (state == PC_HALT) begin
            new_address = current_address;
        end else if (halt && !stall) begin
            new_address = current_address;
            take_halt   = 1'b1;
        end else if (stall) begin
            new_address = current_address;
        end else if (state == PC_RUN && irq_req) begin
            new_address = IRQ_VECTOR;
            take_irq    = 1'b1;
        end else if (state == PC_ISR && eret) begin
            new_address = epc;
            take_eret   = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the ProgramCounter: holds RUN/ISR/HALT state and the saved EPC.
// new_address is combinational; the PC register outside captures it on the next rising edge.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] IRQ_VECTOR   = ADDR_W'(32'h0000_0080)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] current_address,
    output logic [ADDR_W-1:0] new_address,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              eret,
    input  logic              halt,
    input  logic              irq_req,
    output logic              irq_ack,
    output logic [ADDR_W-1:0] epc,
    output logic              in_isr,
    output logic              halted,
    output pc_state_t         dbg_state
);

    // Interrupt handshake: irq_req is a level the requester holds until it sees
    // irq_ack; irq_ack is high exactly in the cycle new_address is IRQ_VECTOR,
    // which also moves the state to ISR, so it can never stay high two cycles.

    pc_state_t         state_q;
    pc_state_t         state_d;
    logic [ADDR_W-1:0] epc_q;
    logic [ADDR_W-1:0] epc_d;
    logic [ADDR_W-1:0] redirect;
    logic              take_irq;
    logic              take_eret;
    logic              take_halt;

    pc_next_mux #(
        .ADDR_W       (ADDR_W),
        .RESET_VECTOR (RESET_VECTOR),
        .IRQ_VECTOR   (IRQ_VECTOR)
    ) u_next_mux (
        .reset           (reset),
        .state           (state_q),
        .current_address (current_address),
        .epc             (epc_q),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .eret            (eret),
        .halt            (halt),
        .irq_req         (irq_req),
        .new_address     (new_address),
        .redirect        (redirect),
        .take_irq        (take_irq),
        .take_eret       (take_eret),
        .take_halt       (take_halt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PC_RUN;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
        end
    end

    // The mux already resolved priority; only one take_* can be set per cycle.
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        if (take_halt) begin
            state_d = PC_HALT;
        end else if (take_irq) begin
            state_d = PC_ISR;
            epc_d   = redirect;
        end else if (take_eret) begin
            state_d = PC_RUN;
        end
    end

    assign irq_ack   = take_irq;
    assign epc       = epc_q;
    assign in_isr    = (state_q == PC_ISR);
    assign halted    = (state_q == PC_HALT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: the bench plays the PC register and
// predicts every new_address/irq_ack/epc/in_isr/halted from the behavioural rules.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] current_address = '0;
    logic [31:0] new_address;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        eret = 1'b0;
    logic        halt = 1'b0;
    logic        irq_req = 1'b0;
    logic        irq_ack;
    logic [31:0] epc;
    logic        in_isr;
    logic        halted;
    logic [1:0]  dbg_state;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .current_address (current_address),
        .new_address     (new_address),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .eret            (eret),
        .halt            (halt),
        .irq_req         (irq_req),
        .irq_ack         (irq_ack),
        .epc             (epc),
        .in_isr          (in_isr),
        .halted          (halted),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pc    = '0;   // the PC register this bench emulates
    logic [31:0] m_epc = '0;
    bit          m_isr = 0;
    bit          m_halted = 0;
    int          halted_cycles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_regs();
        check("epc",    epc,                  m_epc);
        check("in_isr", {31'b0, in_isr},      {31'b0, m_isr});
        check("halted", {31'b0, halted},      {31'b0, m_halted});
    endtask

    // One PC cycle: drive inputs after the falling edge, check the combinational
    // result, then let the rising edge load the PC and advance the model.
    task automatic step(input bit s, input bit bt, input logic [31:0] btg,
                        input bit j, input logic [31:0] jt, input bit er,
                        input bit hl, input bit irq);
        logic [31:0] redir, exp_na, n_epc;
        bit          ack, n_isr, n_halted;
        @(negedge clk);
        stall = s; branch_taken = bt; branch_target = btg; jump = j; jump_target = jt;
        eret = er; halt = hl; irq_req = irq; current_address = pc;
        redir    = j ? (jt & 32'hFFFF_FFFC) : (bt ? (btg & 32'hFFFF_FFFC) : pc + 32'd4);
        ack      = 0;
        n_epc    = m_epc;
        n_isr    = m_isr;
        n_halted = m_halted;
        if (m_halted)              exp_na = pc;
        else if (hl && !s) begin   exp_na = pc; n_halted = 1; n_isr = 0; end
        else if (s)                exp_na = pc;
        else if (!m_isr && irq) begin
            exp_na = 32'h0000_0080; ack = 1; n_epc = redir; n_isr = 1;
        end
        else if (m_isr && er) begin exp_na = m_epc; n_isr = 0; end
        else                       exp_na = redir;
        exp_q.push_back(exp_na);
        #1;
        check("new_address", new_address, exp_q.pop_front());
        check("irq_ack", {31'b0, irq_ack}, {31'b0, ack});
        check_regs();
        @(posedge clk);
        pc = exp_na; m_epc = n_epc; m_isr = n_isr; m_halted = n_halted;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset is raised in the middle of the low clock phase, away from any edge.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst new_address", new_address, 32'h0);
        check("rst irq_ack", {31'b0, irq_ack}, 32'h0);
        check("rst epc", epc, 32'h0);
        check("rst in_isr", {31'b0, in_isr}, 32'h0);
        check("rst halted", {31'b0, halted}, 32'h0);
        stall = 0; branch_taken = 0; jump = 0; eret = 0; halt = 0; irq_req = 0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        pc = 32'h0; m_epc = 0; m_isr = 0; m_halted = 0; halted_cycles = 0;
    endtask

    initial begin : main
        bit          irq_pending;
        logic [31:0] rt;
        // Reset held for two cycles from time zero.
        #1;
        check("init new_address", new_address, 32'h0);
        check("init irq_ack", {31'b0, irq_ack}, 32'h0);
        check("init epc", epc, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(4);                                           // 0 -> 4 -> 8 -> C -> 10

        // Branch with misaligned target, then jump beating branch.
        pc = 32'h10; step(0, 1, 32'h103, 0, 0, 0, 0, 0);
        pc = 32'h10; step(0, 1, 32'h103, 1, 32'h200, 0, 0, 0);

        // Interrupt entry and return.
        pc = 32'h20; step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        check("eret returns", pc, 32'h24);

        // irq held through ISR and stall; ack only after eret on an unstalled cycle.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 32'h400, 0, 0, 1);
        step(0, 0, 0, 1, 32'h400, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0);

        // Wrap at top of memory, then halt and stay frozen.
        pc = 32'hFFFF_FFFC; step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, $urandom, 1, 0, 1);
        check("halt frozen", pc, 32'h0);
        do_reset();

        // Async reset while inside the handler.
        pc = 32'h300; step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        irq_req = 1'b1;
        do_reset();

        // Randomized traffic against the model.
        irq_pending = 0;
        for (int i = 0; i < 600; i++) begin
            if (!irq_pending && $urandom_range(0, 7) == 0) irq_pending = 1;
            rt = $urandom;
            if (m_halted) halted_cycles++;
            if (halted_cycles > 5 || $urandom_range(0, 199) == 0) begin
                do_reset();
                irq_pending = 0;
            end else begin
                step($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom,
                     $urandom_range(0, 5) == 0, rt, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 59) == 0, irq_pending);
                // The requester drops its level once the ack has been seen.
                if (m_isr && m_epc !== 32'hx && exp_ack_seen()) irq_pending = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // irq_pending is cleared once the model has entered the handler.
    function automatic bit exp_ack_seen();
        return m_isr;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
